// File: rtl/cmplx_mult_pipe_pkg.sv
// Shared types and helpers for the pipelined complex multiplier.
// Fixed-width helpers operate on MAX_W-bit values, which covers DATA_W up to 63.
package mult_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int MAX_W      = 128;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] re;
        logic signed [DEF_DATA_W-1:0] im;
    } cplx_t;

    // Rounding constant: one half LSB of the result, i.e. 2^(frac_w-1).
    function automatic logic [MAX_W-1:0] ROUND_HALF(input int frac_w);
        return MAX_W'(1) << (frac_w - 1);
    endfunction

    // Clamp a signed value into the range of a width-bit two's complement number.
    function automatic logic signed [MAX_W-1:0] sat_clip(input logic signed [MAX_W-1:0] value,
                                                         input int width);
        logic signed [MAX_W-1:0] one;
        logic signed [MAX_W-1:0] max_v;
        logic signed [MAX_W-1:0] min_v;
        one   = MAX_W'(1);
        max_v = (one <<< (width - 1)) - one;
        min_v = -(one <<< (width - 1));
        if (value > max_v) return max_v;
        if (value < min_v) return min_v;
        return value;
    endfunction

endpackage

// File: rtl/cmplx_mult_pipe_if.sv
// Handshake and data bundle of the complex multiplier; signal names follow the
// block's point of view (i_* driven into it, o_* driven by it).
interface cmplx_mult_pipe_if #(
    parameter int DATA_W = 16
);
    logic                  i_valid;
    logic                  o_ready;
    logic [2*DATA_W-1:0]   i_mcand;
    logic [2*DATA_W-1:0]   i_mplier;
    logic                  i_conj;
    logic                  o_valid;
    logic                  i_ready;
    logic [2*DATA_W-1:0]   o_result;
    logic                  o_sat;
    logic                  i_clr_sat;

    modport master (
        output i_valid, i_mcand, i_mplier, i_conj, i_ready, i_clr_sat,
        input  o_ready, o_valid, o_result, o_sat
    );

    modport slave (
        input  i_valid, i_mcand, i_mplier, i_conj, i_ready, i_clr_sat,
        output o_ready, o_valid, o_result, o_sat
    );
endinterface

// File: rtl/cmplx_mult_pipe_round_sat.sv
// Combinational round-half-up and saturate of one wide product sum down to
// DATA_W bits, with a flag raised whenever the clamp changed the value.
module cmplx_round_sat
    import mult_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = DATA_W - 1
) (
    input  logic signed [2*DATA_W:0]   sum,
    output logic signed [DATA_W-1:0]   res,
    output logic                       ovf
);
    localparam int SW = 2 * DATA_W + 1;
    localparam logic signed [SW-1:0] HALF = SW'(ROUND_HALF(FRAC_W));

    logic signed [SW-1:0]    shifted;
    logic signed [MAX_W-1:0] wide;
    logic signed [MAX_W-1:0] clipped;

    // NOTE: combinational logic uses blocking '=' so later lines see the
    // freshly computed values within the same evaluation.
    always_comb begin
        shifted = (sum + HALF) >>> FRAC_W;
        wide    = MAX_W'(shifted);
        clipped = sat_clip(wide, DATA_W);
        res     = clipped[DATA_W-1:0];
        ovf     = (clipped != wide);
    end

endmodule

// File: rtl/cmplx_mult_pipe.sv
// Three-stage pipelined complex fixed-point multiplier with optional conjugate,
// round-half-up, saturation, sticky overflow flag and stall-on-backpressure.
module cmplx_mult_pipe
    import mult_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = DATA_W - 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    cmplx_mult_pipe_if.slave  bus
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + 1;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_w_t;

    logic en;

    // S1: registered operands
    logic    v1;
    logic    conj1;
    cplx_w_t a1;
    cplx_w_t b1;

    // S2: partial products
    logic                 v2;
    logic                 conj2;
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ir;
    logic signed [PW-1:0] p_ri;

    // S3: sums, rounding and saturation feeding the output register
    logic signed [SW-1:0]     sum_re;
    logic signed [SW-1:0]     sum_im;
    logic signed [DATA_W-1:0] res_re;
    logic signed [DATA_W-1:0] res_im;
    logic                     ovf_re;
    logic                     ovf_im;

    logic          out_valid;
    logic [PW-1:0] out_result;
    logic          out_sat;

    // The whole pipe freezes only when a result is waiting and nobody takes it.
    assign en           = !(out_valid && !bus.i_ready);
    assign bus.o_ready  = en;
    assign bus.o_valid  = out_valid;
    assign bus.o_result = out_result;
    assign bus.o_sat    = out_sat;

    // NOTE: only control state and the visible outputs are reset; the datapath
    // registers are qualified by their valid bits, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (en) begin
            a1    <= bus.i_mcand;
            b1    <= bus.i_mplier;
            conj1 <= bus.i_conj;
            p_rr  <= PW'(a1.re) * PW'(b1.re);
            p_ii  <= PW'(a1.im) * PW'(b1.im);
            p_ir  <= PW'(a1.im) * PW'(b1.re);
            p_ri  <= PW'(a1.re) * PW'(b1.im);
            conj2 <= conj1;
        end
    end

    always_comb begin
        if (conj2) begin
            sum_re = SW'(p_rr) + SW'(p_ii);
            sum_im = SW'(p_ir) - SW'(p_ri);
        end else begin
            sum_re = SW'(p_rr) - SW'(p_ii);
            sum_im = SW'(p_ir) + SW'(p_ri);
        end
    end

    cmplx_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_round_re (
        .sum (sum_re),
        .res (res_re),
        .ovf (ovf_re)
    );

    cmplx_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_round_im (
        .sum (sum_im),
        .res (res_im),
        .ovf (ovf_im)
    );

    // Setting the sticky flag takes priority over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_sat    <= 1'b0;
        end else begin
            if (en) begin
                v1        <= bus.i_valid;
                v2        <= v1;
                out_valid <= v2;
                if (v2) begin
                    out_result <= {res_re, res_im};
                end
            end
            if (en && v2 && (ovf_re || ovf_im)) begin
                out_sat <= 1'b1;
            end else if (bus.i_clr_sat) begin
                out_sat <= 1'b0;
            end
        end
    end

endmodule
